// File: rtl/regfile_if.sv
// ---------------------------------------------------------------------------
// regfile_if
//   Bundles the register-file access signals between the pipeline and the
//   architectural register file.
//   Write side (driven by MEM/WB):
//     we      write enable
//     waddr   write register address
//     wdata   write data
//   Read side (addresses driven by ID, data returned by the register file):
//     re1/raddr1 -> rdata1   read port 1
//     re2/raddr2 -> rdata2   read port 2
//   Modports:
//     master : pipeline side, which drives the enables, addresses and write data
//     slave  : register file side, which drives the read data
// ---------------------------------------------------------------------------
interface regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile
//   Architectural register file with 32 general registers. It has one
//   synchronous write port, which is the write-back sink. It also has two
//   combinational read ports, which are the operand sources for ID. A write
//   and a read of the same register in the same cycle bypass each other, so
//   ID sees write-back data without a one-cycle bubble. r0 is hard-wired to
//   zero.
//   Ports:
//     clk  in   pipeline clock; all storage updates on its rising edge
//     rst  in   asynchronous active-low reset (0 = reset asserted)
//     bus  slave modport of regfile_if:
//            we/waddr/wdata         write port
//            re1/raddr1 -> rdata1   read port 1
//            re2/raddr2 -> rdata2   read port 2
// ---------------------------------------------------------------------------
module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_en;

  // A write to r0 is dropped here. As a result, regs_q[0] stays 0 after reset.
  assign wr_en = bus.we && (bus.waddr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[bus.waddr] <= bus.wdata;
    end
  end

  // The two read ports are identical. Their inputs are packed so that one
  // generate loop builds both ports.
  logic [1:0]             re_v;
  logic [1:0][ADDR_W-1:0] raddr_v;

  assign re_v    = {bus.re2, bus.re1};
  assign raddr_v = {bus.raddr2, bus.raddr1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [DATA_W-1:0] rdata_d;

      // Priority: reset, disabled port, r0, same-cycle write bypass, storage.
      // The r0 check comes before the bypass, so a write to r0 never leaks
      // through.
      always_comb begin
        rdata_d = '0;
        if (!rst || !re_v[gi] || (raddr_v[gi] == '0)) begin
          rdata_d = '0;
        end else if (bus.we && (raddr_v[gi] == bus.waddr)) begin
          rdata_d = bus.wdata;
        end else begin
          rdata_d = regs_q[raddr_v[gi]];
        end
      end
    end
  endgenerate

  assign bus.rdata1 = g_rd[0].rdata_d;
  assign bus.rdata2 = g_rd[1].rdata_d;

endmodule
